// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one request per cycle to a
// 1-cycle-latency memory and buffers returned words in a DEPTH-entry queue. Define
// FETCH_STATS_EN to add the squash_count statistics output.
module fetch_queue #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AWIDTH = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [AWIDTH-1:0]        imem_addr,
  output logic                     imem_req,
  input  logic [WIDTH-1:0]         imem_data,
  input  logic                     redirect,
  input  logic [AWIDTH-1:0]        redirect_pc,
  input  logic                     halt,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [WIDTH-1:0]         deq_ir,
  output logic [AWIDTH-1:0]        deq_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]              squash_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  logic [AWIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [AWIDTH-1:0] pending_pc, pending_pc_n;
  logic              inflight, inflight_n;
  logic [PW-1:0]     head, head_n;
  logic [PW-1:0]     tail, tail_n;
  logic [CW-1:0]     count_n;
  logic [OW-1:0]     occupancy;
  logic              enq;
  logic              deq;

  logic [WIDTH-1:0]  ir_mem [DEPTH];
  logic [AWIDTH-1:0] pc_mem [DEPTH];

  // Request credit counts both held and in-flight words so a response always has a slot.
  always_comb begin
    occupancy = OW'(count) + OW'(inflight);
    imem_req  = !reset && !halt && !redirect && (occupancy < OW'(DEPTH));
    imem_addr = fetch_pc;
    deq_valid = !reset && (count != '0);
    deq_ir    = ir_mem[head];
    deq_pc    = pc_mem[head];
    enq       = inflight && !redirect && !reset;
    deq       = deq_valid && deq_ready;
  end

  // Next-state: redirect flushes everything and reloads the PC.
  always_comb begin
    fetch_pc_n   = fetch_pc;
    pending_pc_n = pending_pc;
    inflight_n   = imem_req;
    head_n       = head;
    tail_n       = tail;
    count_n      = count;
    if (redirect) begin
      fetch_pc_n = redirect_pc;
      inflight_n = 1'b0;
      head_n     = '0;
      tail_n     = '0;
      count_n    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_n   = fetch_pc + AWIDTH'(1);
        pending_pc_n = fetch_pc;
      end
      if (enq) tail_n = tail + PW'(1);
      if (deq) head_n = head + PW'(1);
      case ({enq, deq})
        2'b10:   count_n = count + CW'(1);
        2'b01:   count_n = count - CW'(1);
        default: count_n = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= '0;
      pending_pc <= '0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      fetch_pc   <= fetch_pc_n;
      pending_pc <= pending_pc_n;
      inflight   <= inflight_n;
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
    end
  end

  // Queue storage needs no reset; entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      ir_mem[tail] <= imem_data;
      pc_mem[tail] <= pending_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic [16:0] squash_sum;

  // Words thrown away by a redirect: those held plus the one still in flight.
  always_comb begin
    squash_sum = 17'(squash_count) + 17'(count) + 17'(inflight);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      squash_count <= '0;
    end else if (redirect) begin
      squash_count <= squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-level reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        deq_valid;
  logic        deq_ready;
  logic [15:0] deq_ir;
  logic [15:0] deq_pc;
  logic [2:0]  count;
`ifdef FETCH_STATS_EN
  logic [15:0] squash_count;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: fetch PC, queue of buffered PCs, one in-flight slot.
  logic [15:0] m_pc;
  logic [15:0] m_infl_pc;
  bit          m_infl;
  logic [15:0] m_q[$];
  int unsigned m_squash;

  fetch_queue #(.WIDTH(16), .AWIDTH(16), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_ir      (deq_ir),
    .deq_pc      (deq_pc),
    .count       (count)
`ifdef FETCH_STATS_EN
    ,
    .squash_count(squash_count)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: mem[i] = 0x1000 + i, one cycle latency.
  always @(posedge clk) imem_data <= 16'h1000 + imem_addr;

  function automatic logic [15:0] ir_of(input logic [15:0] pc);
    return 16'h1000 + pc;
  endfunction

  function automatic bit model_req();
    return !reset && !halt && !redirect && ((m_q.size() + int'(m_infl)) < int'(DEPTH));
  endfunction

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    bit req;
    int unsigned s;
    req = model_req();
    @(posedge clk);
    if (reset) begin
      m_pc = '0; m_q.delete(); m_infl = 0; m_infl_pc = '0; m_squash = 0;
    end else if (redirect) begin
      s = m_squash + m_q.size() + int'(m_infl);
      m_squash = (s > 65535) ? 65535 : s;
      m_q.delete(); m_infl = 0; m_pc = redirect_pc;
    end else begin
      if (m_q.size() != 0 && deq_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl = req;
      if (req) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; redirect = 1'b0; halt = 1'b0; deq_ready = 1'b0; redirect_pc = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; halt = 1'b0; deq_ready = 1'b0; redirect_pc = '0;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else passed++;
    total++; if (deq_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", deq_valid); else passed++;
    tick(); tick();
    total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (imem_addr !== 16'h0000) $display("FAIL reset_addr got %h want 0000", imem_addr); else passed++;
    reset = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) $display("FAIL reset_release_req got %b want 1", imem_req); else passed++;
    total++; if (deq_valid !== 1'b0) $display("FAIL reset_release_valid got %b want 0", deq_valid); else passed++;
  endtask

  task automatic test_stream();
    apply_reset();
    deq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'(k))
        $display("FAIL stream_addr c%0d got %b/%h want 1/%h", k, imem_req, imem_addr, 16'(k)); else passed++;
      total++; if (deq_valid !== (k >= 2))
        $display("FAIL stream_valid c%0d got %b want %b", k, deq_valid, (k >= 2)); else passed++;
      if (k >= 2) begin
        total++; if (deq_pc !== 16'(k - 2) || deq_ir !== 16'h1000 + 16'(k - 2))
          $display("FAIL stream_data c%0d got %h/%h want %h/%h", k, deq_pc, deq_ir, 16'(k - 2), 16'h1000 + 16'(k - 2));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int unsigned issued;
    int unsigned nxt;
    bit seen_req;
    apply_reset();
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (imem_req) begin
        total++; if (imem_addr !== 16'(issued))
          $display("FAIL bp_addr got %h want %h", imem_addr, 16'(issued)); else passed++;
        issued++;
      end
      tick();
    end
    #1;
    total++; if (issued != 4) $display("FAIL bp_issued got %0d want 4", issued); else passed++;
    total++; if (count !== 3'd4) $display("FAIL bp_count got %0d want 4", count); else passed++;
    total++; if (imem_req !== 1'b0 || imem_addr !== 16'h0004)
      $display("FAIL bp_stall got %b/%h want 0/0004", imem_req, imem_addr); else passed++;
    deq_ready = 1'b1;
    nxt = 0; seen_req = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (deq_valid) begin
        total++; if (deq_pc !== 16'(nxt) || deq_ir !== ir_of(16'(nxt)))
          $display("FAIL bp_order got %h/%h want %h/%h", deq_pc, deq_ir, 16'(nxt), ir_of(16'(nxt))); else passed++;
        nxt++;
      end
      if (imem_req && !seen_req) begin
        seen_req = 1;
        total++; if (imem_addr !== 16'h0004)
          $display("FAIL bp_resume got %h want 0004", imem_addr); else passed++;
      end
      tick();
    end
    total++; if (nxt < 8) $display("FAIL bp_drained got %0d want >=8", nxt); else passed++;
  endtask

  task automatic test_redirect();
    bit found;
    apply_reset();
    for (int c = 0; c < 4; c++) tick();
    #1;
    total++; if (count !== 3'd3 || imem_req !== 1'b0)
      $display("FAIL redir_pre got %0d/%b want 3/0", count, imem_req); else passed++;
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL redir_req got %b want 0", imem_req); else passed++;
    tick();
    redirect = 1'b0;
    #1;
    total++; if (count !== 3'd0 || deq_valid !== 1'b0)
      $display("FAIL redir_flush got %0d/%b want 0/0", count, deq_valid); else passed++;
    total++; if (imem_addr !== 16'h0040 || imem_req !== 1'b1)
      $display("FAIL redir_addr got %h/%b want 0040/1", imem_addr, imem_req); else passed++;
`ifdef FETCH_STATS_EN
    total++; if (squash_count !== 16'd4) $display("FAIL redir_squash got %0d want 4", squash_count); else passed++;
`endif
    deq_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (deq_valid) begin
        found = 1;
        total++; if (deq_pc !== 16'h0040 || deq_ir !== 16'h1040)
          $display("FAIL redir_first got %h/%h want 0040/1040", deq_pc, deq_ir); else passed++;
      end
      tick();
    end
    if (!found) begin
      total++; $display("FAIL redir_timeout got none want deq_valid");
    end
  endtask

  task automatic test_halt();
    int unsigned nxt;
    apply_reset();
    deq_ready = 1'b1;
    nxt = 0;
    for (int c = 0; c <= 20; c++) begin
      halt = (c >= 5 && c < 12);
      #1;
      if (c == 5) begin
        total++; if (imem_addr !== 16'h0005) $display("FAIL halt_pc got %h want 0005", imem_addr); else passed++;
      end
      if (halt) begin
        total++; if (imem_req !== 1'b0) $display("FAIL halt_req c%0d got %b want 0", c, imem_req); else passed++;
      end
      if (c == 11) begin
        total++; if (count !== 3'd0) $display("FAIL halt_drain got %0d want 0", count); else passed++;
      end
      if (c == 12) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005)
          $display("FAIL halt_resume got %b/%h want 1/0005", imem_req, imem_addr); else passed++;
      end
      if (deq_valid) begin
        total++; if (deq_pc !== 16'(nxt))
          $display("FAIL halt_order got %h want %h", deq_pc, 16'(nxt)); else passed++;
        nxt++;
      end
      tick();
    end
    halt = 1'b0;
    total++; if (nxt != 12) $display("FAIL halt_total got %0d want 12", nxt); else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_w [4];
    int unsigned j;
    exp_w = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    apply_reset();
    deq_ready = 1'b1;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    j = 0;
    for (int c = 0; c < 20 && j < 4; c++) begin
      #1;
      if (deq_valid) begin
        total++; if (deq_pc !== exp_w[j] || deq_ir !== ir_of(exp_w[j]))
          $display("FAIL wrap_%0d got %h/%h want %h/%h", j, deq_pc, deq_ir, exp_w[j], ir_of(exp_w[j])); else passed++;
        j++;
      end
      tick();
    end
    if (j < 4) begin
      total++; $display("FAIL wrap_timeout got %0d want 4", j);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    apply_reset();
    for (int c = 0; c < 4; c++) tick();
    #1;
    total++; if (count !== 3'd3) $display("FAIL rmid_pre got %0d want 3", count); else passed++;
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || deq_valid !== 1'b0)
      $display("FAIL rmid_during got %b/%b want 0/0", imem_req, deq_valid); else passed++;
    tick();
    #1;
    total++; if (count !== 3'd0 || deq_valid !== 1'b0 || imem_addr !== 16'h0000)
      $display("FAIL rmid_after got %0d/%b/%h want 0/0/0000", count, deq_valid, imem_addr); else passed++;
    reset = 1'b0; deq_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (deq_valid) begin
        found = 1;
        total++; if (deq_pc !== 16'h0000 || deq_ir !== 16'h1000)
          $display("FAIL rmid_first got %h/%h want 0000/1000", deq_pc, deq_ir); else passed++;
      end
      tick();
    end
    if (!found) begin
      total++; $display("FAIL rmid_timeout got none want deq_valid");
    end
  endtask

  task automatic test_random();
    bit          ereq;
    bit          evalid;
    int unsigned errs;
    apply_reset();
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      redirect  = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      deq_ready = ($urandom_range(0, 9) < 7);
      #1;
      ereq   = model_req();
      evalid = !reset && (m_q.size() != 0);
      total++; if (imem_req !== ereq || imem_addr !== m_pc) begin
        errs++;
        if (errs < 20) $display("FAIL rnd_req c%0d got %b/%h want %b/%h", c, imem_req, imem_addr, ereq, m_pc);
      end else passed++;
      total++; if (deq_valid !== evalid || count !== 3'(m_q.size())) begin
        errs++;
        if (errs < 20) $display("FAIL rnd_occ c%0d got %b/%0d want %b/%0d", c, deq_valid, count, evalid, m_q.size());
      end else passed++;
      if (evalid) begin
        total++; if (deq_pc !== m_q[0] || deq_ir !== ir_of(m_q[0])) begin
          errs++;
          if (errs < 20) $display("FAIL rnd_head c%0d got %h/%h want %h/%h", c, deq_pc, deq_ir, m_q[0], ir_of(m_q[0]));
        end else passed++;
      end
`ifdef FETCH_STATS_EN
      total++; if (squash_count !== 16'(m_squash)) begin
        errs++;
        if (errs < 20) $display("FAIL rnd_squash c%0d got %0d want %0d", c, squash_count, m_squash);
      end else passed++;
`endif
      tick();
    end
    reset = 1'b0; redirect = 1'b0; halt = 1'b0;
  endtask

  initial begin
    m_pc = '0; m_infl_pc = '0; m_infl = 0; m_squash = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
